// File: rtl/writeback_unit.sv
// Writeback unit: three one-entry result slots (INT/VEC/LSU) arbitrated onto one register-file write port.
// Define WB_FIXED_PRIORITY_EN for fixed LSU > INT > VEC priority instead of round-robin.
module writeback_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock_in,
  input  logic                      reset_n_in,
  input  logic                      flush_in,
  input  logic                      int_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] int_rd_in,
  input  logic [DATA_WIDTH-1:0]     int_data_in,
  output logic                      int_ready_out,
  input  logic                      vec_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] vec_rd_in,
  input  logic [DATA_WIDTH-1:0]     vec_data_in,
  output logic                      vec_ready_out,
  input  logic                      lsu_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd_in,
  input  logic [DATA_WIDTH-1:0]     lsu_data_in,
  output logic                      lsu_ready_out,
  output logic                      wb_valid_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_out,
  output logic [DATA_WIDTH-1:0]     wb_data_out,
  output logic [2:0]                wb_unit_out
);

  // Slot index i matches bit i of the one-hot unit code: 0 INT, 1 VEC, 2 LSU.
  logic [2:0]                in_valid_s;
  logic [REG_ADDR_WIDTH-1:0] in_rd_s   [3];
  logic [DATA_WIDTH-1:0]     in_data_s [3];
  logic [2:0]                full_r;
  logic [REG_ADDR_WIDTH-1:0] rd_r      [3];
  logic [DATA_WIDTH-1:0]     data_r    [3];
  logic [2:0]                grant_s;
  logic [2:0]                ready_s;
  logic [REG_ADDR_WIDTH-1:0] sel_rd_s;
  logic [DATA_WIDTH-1:0]     sel_data_s;

  assign in_valid_s   = {lsu_valid_in, vec_valid_in, int_valid_in};
  assign in_rd_s[0]   = int_rd_in;
  assign in_rd_s[1]   = vec_rd_in;
  assign in_rd_s[2]   = lsu_rd_in;
  assign in_data_s[0] = int_data_in;
  assign in_data_s[1] = vec_data_in;
  assign in_data_s[2] = lsu_data_in;

  // Grant depends only on registered state, so ready never combinationally follows valid.
  assign ready_s       = ~full_r | grant_s;
  assign int_ready_out = ready_s[0];
  assign vec_ready_out = ready_s[1];
  assign lsu_ready_out = ready_s[2];

`ifdef WB_FIXED_PRIORITY_EN
  // Fixed-priority arbiter: LSU, then INT, then VEC.
  always_comb begin
    grant_s = 3'b000;
    if (full_r[2]) begin
      grant_s = 3'b100;
    end else if (full_r[0]) begin
      grant_s = 3'b001;
    end else if (full_r[1]) begin
      grant_s = 3'b010;
    end else begin
      grant_s = 3'b000;
    end
  end
`else
  logic [2:0] ptr_r;

  // Round-robin arbiter: search starts at the unit after the last granted one.
  always_comb begin
    grant_s = 3'b000;
    case (ptr_r)
      3'b001: begin
        if (full_r[1])      grant_s = 3'b010;
        else if (full_r[2]) grant_s = 3'b100;
        else if (full_r[0]) grant_s = 3'b001;
        else                grant_s = 3'b000;
      end
      3'b010: begin
        if (full_r[2])      grant_s = 3'b100;
        else if (full_r[0]) grant_s = 3'b001;
        else if (full_r[1]) grant_s = 3'b010;
        else                grant_s = 3'b000;
      end
      default: begin
        if (full_r[0])      grant_s = 3'b001;
        else if (full_r[1]) grant_s = 3'b010;
        else if (full_r[2]) grant_s = 3'b100;
        else                grant_s = 3'b000;
      end
    endcase
  end

  // Pointer remembers the last granted unit; flush leaves it alone.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ptr_r <= 3'b100;
    end else if (!flush_in && (grant_s != 3'b000)) begin
      ptr_r <= grant_s;
    end
  end
`endif

  // Select the granted slot's payload.
  always_comb begin
    sel_rd_s   = {REG_ADDR_WIDTH{1'b0}};
    sel_data_s = {DATA_WIDTH{1'b0}};
    case (grant_s)
      3'b001: begin
        sel_rd_s   = rd_r[0];
        sel_data_s = data_r[0];
      end
      3'b010: begin
        sel_rd_s   = rd_r[1];
        sel_data_s = data_r[1];
      end
      3'b100: begin
        sel_rd_s   = rd_r[2];
        sel_data_s = data_r[2];
      end
      default: begin
        sel_rd_s   = {REG_ADDR_WIDTH{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Holding slots: a refill on the grant edge wins over the drain.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      full_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        rd_r[i]   <= {REG_ADDR_WIDTH{1'b0}};
        data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (flush_in) begin
      full_r <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_valid_s[i] && ready_s[i]) begin
          full_r[i] <= 1'b1;
          rd_r[i]   <= in_rd_s[i];
          data_r[i] <= in_data_s[i];
        end else if (grant_s[i]) begin
          full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Writeback register; x0 destinations are drained without raising the strobe.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wb_valid_out <= 1'b0;
      wb_rd_out    <= {REG_ADDR_WIDTH{1'b0}};
      wb_data_out  <= {DATA_WIDTH{1'b0}};
      wb_unit_out  <= 3'b000;
    end else if (flush_in) begin
      wb_valid_out <= 1'b0;
      wb_unit_out  <= 3'b000;
    end else if (grant_s != 3'b000) begin
      wb_valid_out <= (sel_rd_s != {REG_ADDR_WIDTH{1'b0}});
      wb_rd_out    <= sel_rd_s;
      wb_data_out  <= sel_data_s;
      wb_unit_out  <= grant_s;
    end else begin
      wb_valid_out <= 1'b0;
      wb_unit_out  <= 3'b000;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, hand sequences, randomized run vs. model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  v;
  logic [4:0]  rdv [3];
  logic [31:0] dv  [3];
  logic        int_ready, vec_ready, lsu_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_unit;
  logic [2:0]  rdy;

  int n_chk  = 0;
  int n_fail = 0;

  assign rdy = {lsu_ready, vec_ready, int_ready};

  always #5 clk = ~clk;

  writeback_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock_in(clk), .reset_n_in(rst_n), .flush_in(flush),
    .int_valid_in(v[0]), .int_rd_in(rdv[0]), .int_data_in(dv[0]), .int_ready_out(int_ready),
    .vec_valid_in(v[1]), .vec_rd_in(rdv[1]), .vec_data_in(dv[1]), .vec_ready_out(vec_ready),
    .lsu_valid_in(v[2]), .lsu_rd_in(rdv[2]), .lsu_data_in(dv[2]), .lsu_ready_out(lsu_ready),
    .wb_valid_out(wb_valid), .wb_rd_out(wb_rd), .wb_data_out(wb_data), .wb_unit_out(wb_unit)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v = 3'b000;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdv[i] = 5'd0;
      dv[i]  = 32'd0;
    end
  endtask

  // Directed vector table
  typedef struct {
    logic [2:0]  v;
    logic [4:0]  r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic [2:0]  eu;
    logic [2:0]  er;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk_idle(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                                   input logic [2:0] eu, input logic [2:0] er);
    vec_t t;
    t = '{3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, ev, erd, ed, eu, er};
    return t;
  endfunction

  // Behavioural reference model
  bit          m_full [3];
  logic [4:0]  m_rd   [3];
  logic [31:0] m_data [3];
  int          m_last;
  logic        m_wv;
  logic [4:0]  m_wrd;
  logic [31:0] m_wdata;
  logic [2:0]  m_wunit;

  function automatic int m_grant();
`ifdef WB_FIXED_PRIORITY_EN
    int order [3] = '{2, 0, 1};
    for (int k = 0; k < 3; k++) if (m_full[order[k]]) return order[k];
`else
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_last + 1 + k) % 3;
      if (m_full[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    int g;
    logic [2:0] r;
    g = m_grant();
    for (int i = 0; i < 3; i++) r[i] = !m_full[i] || (g == i);
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_rd[i]   = 5'd0;
      m_data[i] = 32'd0;
    end
    m_last = 2;
    m_wv = 1'b0; m_wrd = 5'd0; m_wdata = 32'd0; m_wunit = 3'b000;
  endtask

  task automatic m_step();
    int g;
    logic [2:0] r;
    logic [4:0] grd;
    logic [31:0] gdata;
    g = m_grant();
    r = m_ready();
    if (flush) begin
      for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
      m_wv = 1'b0;
      m_wunit = 3'b000;
    end else begin
      if (g >= 0) begin
        grd = m_rd[g];
        gdata = m_data[g];
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && r[i]) begin
          m_full[i] = 1'b1;
          m_rd[i] = rdv[i];
          m_data[i] = dv[i];
        end else if (g == i) begin
          m_full[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        m_wv = (grd != 5'd0);
        m_wrd = grd;
        m_wdata = gdata;
        m_wunit = 3'(1 << g);
        m_last = g;
      end else begin
        m_wv = 1'b0;
        m_wunit = 3'b000;
      end
    end
  endtask

  logic [4:0]  held_rd;
  logic [31:0] held_d;
  logic [2:0]  pend;
  logic [2:0]  mr;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;

    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_wb_unit", 64'(wb_unit), 64'd0);
    chk("reset_wb_rd", 64'(wb_rd), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    chk("reset_ready", 64'(rdy), 64'h7);

    tbl[0] = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 32'd0, 3'b000,
`ifdef WB_FIXED_PRIORITY_EN
               3'b100};
    tbl[1] = mk_idle(1'b1, 5'd3, 32'h33, 3'b100, 3'b101);
    tbl[2] = mk_idle(1'b1, 5'd1, 32'h11, 3'b001, 3'b111);
    tbl[3] = mk_idle(1'b1, 5'd2, 32'h22, 3'b010, 3'b111);
    held_rd = 5'd2; held_d = 32'h22;
`else
               3'b001};
    tbl[1] = mk_idle(1'b1, 5'd1, 32'h11, 3'b001, 3'b011);
    tbl[2] = mk_idle(1'b1, 5'd2, 32'h22, 3'b010, 3'b111);
    tbl[3] = mk_idle(1'b1, 5'd3, 32'h33, 3'b100, 3'b111);
    held_rd = 5'd3; held_d = 32'h33;
`endif
    tbl[4] = mk_idle(1'b0, held_rd, held_d, 3'b000, 3'b111);
    tbl[5] = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, held_rd, held_d, 3'b000, 3'b111};
    tbl[6] = mk_idle(1'b1, 5'd5, 32'hDEADBEEF, 3'b001, 3'b111);
    tbl[7] = mk_idle(1'b0, 5'd5, 32'hDEADBEEF, 3'b000, 3'b111);
    tbl[8] = '{3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h55, 1'b0, 5'd5, 32'hDEADBEEF, 3'b000, 3'b111};
    tbl[9] = mk_idle(1'b0, 5'd0, 32'h55, 3'b100, 3'b111);
    tbl[10] = mk_idle(1'b0, 5'd0, 32'h55, 3'b000, 3'b111);

    for (int n = 0; n < 11; n++) begin
      v = tbl[n].v;
      rdv[0] = tbl[n].r0; rdv[1] = tbl[n].r1; rdv[2] = tbl[n].r2;
      dv[0] = tbl[n].d0; dv[1] = tbl[n].d1; dv[2] = tbl[n].d2;
      tick();
      chk($sformatf("tbl%0d_valid", n), 64'(wb_valid), 64'(tbl[n].ev));
      chk($sformatf("tbl%0d_rd", n), 64'(wb_rd), 64'(tbl[n].erd));
      chk($sformatf("tbl%0d_data", n), 64'(wb_data), 64'(tbl[n].ed));
      chk($sformatf("tbl%0d_unit", n), 64'(wb_unit), 64'(tbl[n].eu));
      chk($sformatf("tbl%0d_ready", n), 64'(rdy), 64'(tbl[n].er));
    end
    idle_inputs();

    // Back-to-back INT stream: one write per cycle, no bubbles
    for (int k = 0; k < 12; k++) begin
      v = 3'b001; rdv[0] = 5'd7; dv[0] = 32'(k);
      #1;
      chk("stream_int_ready", 64'(int_ready), 64'd1);
      tick();
      if (k >= 1) begin
        chk("stream_valid", 64'(wb_valid), 64'd1);
        chk("stream_rd", 64'(wb_rd), 64'd7);
        chk("stream_data", 64'(wb_data), 64'(k - 1));
      end
    end
    idle_inputs();
    tick();
    chk("stream_last_data", 64'(wb_data), 64'd11);
    tick();
    chk("stream_end_valid", 64'(wb_valid), 64'd0);

    // Flush with two full slots, then a fresh VEC result
    v = 3'b011; rdv[0] = 5'd4; dv[0] = 32'h44; rdv[1] = 5'd6; dv[1] = 32'h66;
    tick();
    idle_inputs();
    flush = 1'b1; v = 3'b100; rdv[2] = 5'd8; dv[2] = 32'h88;
    #1;
    chk("flush_cycle_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    idle_inputs();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_unit", 64'(wb_unit), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_flush_no_write", 64'({wb_valid, wb_unit}), 64'd0);
    end
    v = 3'b010; rdv[1] = 5'd9; dv[1] = 32'h99;
    tick();
    idle_inputs();
    chk("vec_after_flush_early", 64'(wb_valid), 64'd0);
    tick();
    chk("vec_after_flush_valid", 64'(wb_valid), 64'd1);
    chk("vec_after_flush_rd", 64'(wb_rd), 64'd9);
    chk("vec_after_flush_data", 64'(wb_data), 64'h99);
    chk("vec_after_flush_unit", 64'(wb_unit), 64'b010);
    tick();

    // Asynchronous reset with all slots full
    v = 3'b111; rdv[0] = 5'd10; rdv[1] = 5'd11; rdv[2] = 5'd12;
    dv[0] = 32'hA; dv[1] = 32'hB; dv[2] = 32'hC;
    tick();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(wb_valid), 64'd0);
    chk("async_reset_ready", 64'(rdy), 64'h7);
    chk("async_reset_rd", 64'(wb_rd), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("after_reset_no_write", 64'({wb_valid, wb_unit}), 64'd0);
    end

    // Randomized run against the model
    m_reset();
    pend = 3'b000;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          v[i] = ($urandom_range(0, 99) < 60);
          rdv[i] = 5'($urandom_range(0, 31));
          dv[i] = $urandom;
        end
      end
      flush = ($urandom_range(0, 99) < 4);
      #1;
      mr = m_ready();
      chk("rand_ready", 64'(rdy), 64'(mr));
      pend = v & ~mr;
      m_step();
      tick();
      chk("rand_valid", 64'(wb_valid), 64'(m_wv));
      chk("rand_unit", 64'(wb_unit), 64'(m_wunit));
      chk("rand_rd", 64'(wb_rd), 64'(m_wrd));
      chk("rand_data", 64'(wb_data), 64'(m_wdata));
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
